// File: rtl/ym_pcm_fetch_sched_pkg.sv
// Shared constants and FSM encoding for the YM2610 ADPCM sample-ROM fetch path.
// Channels 0-5 are ADPCM-A; channel 6 is ADPCM-B.
package ym_pkg;

    localparam int unsigned NCH_A = 6;
    localparam int unsigned CH_B  = 6;
    localparam int unsigned NCH   = 7;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE
    } fsm_e;

    typedef logic [2:0] ch_t;

    // Next channel index in round-robin order, wrapping 6 -> 0.
    function automatic ch_t rr_next(input ch_t c);
        return (c == ch_t'(NCH - 1)) ? '0 : c + ch_t'(1);
    endfunction

endpackage

// File: rtl/ym_pcm_fetch_sched_if.sv
// Byte-wide sample-ROM port shared by all ADPCM channels.
// The scheduler is the master; the ROM model or controller is the slave.
interface ym_pcm_fetch_sched_if #(
    parameter int unsigned ADDR_W = 24
);
    logic              ROM_REQ;
    logic [ADDR_W-1:0] ROM_ADDR;
    logic              ROM_ACK;
    logic [7:0]        ROM_DATA;

    modport master (
        output ROM_REQ,
        output ROM_ADDR,
        input  ROM_ACK,
        input  ROM_DATA
    );

    modport slave (
        input  ROM_REQ,
        input  ROM_ADDR,
        output ROM_ACK,
        output ROM_DATA
    );
endinterface

// File: rtl/ym_rr_arbiter.sv
// 7-way round-robin arbiter: the search starts one past the last granted channel.
// The pointer only moves when the caller actually takes the grant.
module ym_rr_arbiter
    import ym_pkg::*;
(
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic [NCH-1:0] req_i,
    input  logic           take_i,
    output logic           gnt_valid_o,
    output ch_t            gnt_o
);

    ch_t last_q, last_d;

    always_comb begin
        ch_t c;
        gnt_valid_o = 1'b0;
        gnt_o       = '0;
        c           = rr_next(last_q);
        for (int unsigned k = 0; k < NCH; k++) begin
            if (!gnt_valid_o && req_i[c]) begin
                gnt_valid_o = 1'b1;
                gnt_o       = c;
            end
            c = rr_next(c);
        end
    end

    always_comb begin
        last_d = last_q;
        if (take_i && gnt_valid_o) begin
            last_d = gnt_o;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            last_q <= ch_t'(NCH - 1);
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/ym_pcm_fetch_sched.sv
// Sample-ROM fetch scheduler: tracks per-channel play state/address and serves
// decoder byte requests one at a time over a shared ROM port.
module ym_pcm_fetch_sched
    import ym_pkg::*;
#(
    parameter int unsigned ADDR_W = 24
) (
    input  logic                  PHI_M,
    input  logic                  nRESET,
    input  logic [NCH_A-1:0]      PCMA_KEYON,
    input  logic [NCH_A-1:0]      PCMA_KEYOFF,
    input  logic [16*NCH_A-1:0]   PCMA_START,
    input  logic [16*NCH_A-1:0]   PCMA_STOP,
    input  logic                  PCMB_START,
    input  logic                  PCMB_RESET,
    input  logic                  PCMB_REPEAT,
    input  logic [15:0]           PCMB_START_ADDR,
    input  logic [15:0]           PCMB_STOP_ADDR,
    input  logic [NCH-1:0]        NEED,
    ym_pcm_fetch_sched_if.master  rom,
    output logic                  DATA_VALID,
    output logic [2:0]            DATA_CH,
    output logic [7:0]            DATA_OUT,
    output logic [NCH-1:0]        END,
    output logic [NCH-1:0]        ACTIVE
);

    fsm_e              state_q, state_d;
    ch_t               ch_q, ch_d;
    logic              stale_q, stale_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [7:0]        data_q, data_d;
    logic [NCH-1:0]    active_q, active_d;
    logic [NCH-1:0]    pending_q, pending_d;
    logic [ADDR_W-1:0] addr_q [NCH];
    logic [ADDR_W-1:0] addr_d [NCH];

    logic [15:0]       start_w [NCH];
    logic [15:0]       stop_w  [NCH];
    logic [NCH-1:0]    keyon_v, keyoff_v;
    logic              gnt_valid, take;
    ch_t               gnt;

    always_comb begin
        for (int unsigned i = 0; i < NCH_A; i++) begin
            start_w[i] = PCMA_START[16*i +: 16];
            stop_w[i]  = PCMA_STOP[16*i +: 16];
        end
        start_w[CH_B] = PCMB_START_ADDR;
        stop_w[CH_B]  = PCMB_STOP_ADDR;
    end

    assign keyon_v  = {PCMB_START, PCMA_KEYON};
    assign keyoff_v = {PCMB_RESET, PCMA_KEYOFF};

    ym_rr_arbiter u_arb (
        .clk_i       (PHI_M),
        .rst_ni      (nRESET),
        .req_i       (pending_q & active_q),
        .take_i      (take),
        .gnt_valid_o (gnt_valid),
        .gnt_o       (gnt)
    );

    assign rom.ROM_REQ  = (state_q == REQ);
    assign rom.ROM_ADDR = rom_addr_q;
    assign DATA_CH      = ch_q;
    assign DATA_OUT     = data_q;
    assign ACTIVE       = active_q;

    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        stale_d    = stale_q;
        rom_addr_d = rom_addr_q;
        data_d     = data_q;
        active_d   = active_q;
        pending_d  = pending_q | (NEED & active_q);
        addr_d     = addr_q;
        take       = 1'b0;
        DATA_VALID = 1'b0;
        END        = '0;

        unique case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    take       = 1'b1;
                    ch_d       = gnt;
                    rom_addr_d = addr_q[gnt];
                    stale_d    = 1'b0;
                    state_d    = REQ;
                end
            end
            REQ: begin
                if (rom.ROM_ACK) begin
                    data_d  = rom.ROM_DATA;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                if (!stale_q) begin
                    DATA_VALID     = 1'b1;
                    pending_d[ch_q] = 1'b0;
                    if (rom_addr_q == {stop_w[ch_q][ADDR_W-9:0], 8'hFF}) begin
                        if (ch_q == ch_t'(CH_B) && PCMB_REPEAT) begin
                            addr_d[ch_q] = {start_w[ch_q][ADDR_W-9:0], 8'h00};
                        end else begin
                            active_d[ch_q] = 1'b0;
                            END[ch_q]      = 1'b1;
                        end
                    end else begin
                        addr_d[ch_q] = rom_addr_q + ADDR_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Key events are applied last so they override the DONE-cycle update; a fetch
        // that is in flight (or being granted this cycle) for that channel turns stale.
        for (int unsigned i = 0; i < NCH; i++) begin
            if (keyoff_v[i]) begin
                active_d[i]  = 1'b0;
                pending_d[i] = 1'b0;
            end else if (keyon_v[i]) begin
                active_d[i]  = 1'b1;
                pending_d[i] = 1'b0;
                addr_d[i]    = {start_w[i][ADDR_W-9:0], 8'h00};
            end
            if ((keyon_v[i] || keyoff_v[i]) &&
                ((state_q == REQ && ch_q == ch_t'(i)) ||
                 (state_q == IDLE && gnt_valid && gnt == ch_t'(i)))) begin
                stale_d = 1'b1;
            end
        end
    end

    always_ff @(posedge PHI_M) begin
        if (!nRESET) begin
            state_q    <= IDLE;
            ch_q       <= '0;
            stale_q    <= 1'b0;
            rom_addr_q <= '0;
            data_q     <= '0;
            active_q   <= '0;
            pending_q  <= '0;
            for (int unsigned i = 0; i < NCH; i++) begin
                addr_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            stale_q    <= stale_d;
            rom_addr_q <= rom_addr_d;
            data_q     <= data_d;
            active_q   <= active_d;
            pending_q  <= pending_d;
            addr_q     <= addr_d;
        end
    end

endmodule
